// File: rtl/led_adder_sequencer.sv
// Tiny Tapeout controller for the shared 8-bit add/sub datapath: captures A and B on
// separate strobes, computes in one cycle, then holds the result for a display window.
module led_adder_sequencer #(
    parameter int unsigned HOLD_CYCLES    = 16,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_B  = 2'd1,
        COMPUTE = 2'd2,
        SHOW    = 2'd3
    } state_t;

    state_t           state, state_n;
    logic [7:0]       a_q, a_n, b_q, b_n, result_q, result_n;
    logic             carry_q, carry_n, valid_q, valid_n, err_q, err_n, op_q, op_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             start_d, b_d;
    logic             start_rise, b_rise, abort, busy;
    logic [8:0]       sum, diff;
    logic             unused;

    assign start_rise = ui_in[0] & ~start_d;
    assign b_rise     = ui_in[1] & ~b_d;
    assign abort      = ui_in[4];
    assign busy       = (state != IDLE);

    // Bit 8 of the 9-bit difference is the borrow (set exactly when a_q < b_q).
    assign sum  = {1'b0, a_q} + {1'b0, b_q};
    assign diff = {1'b0, a_q} - {1'b0, b_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            op_q     <= 1'b0;
            cnt      <= '0;
            start_d  <= 1'b0;
            b_d      <= 1'b0;
        end else begin
            state    <= state_n;
            a_q      <= a_n;
            b_q      <= b_n;
            result_q <= result_n;
            carry_q  <= carry_n;
            valid_q  <= valid_n;
            err_q    <= err_n;
            op_q     <= op_n;
            cnt      <= cnt_n;
            start_d  <= ui_in[0];
            b_d      <= ui_in[1];
        end
    end

    always_comb begin
        state_n  = state;
        a_n      = a_q;
        b_n      = b_q;
        result_n = result_q;
        carry_n  = carry_q;
        valid_n  = valid_q;
        err_n    = err_q;
        op_n     = op_q;
        cnt_n    = cnt;
        if (abort) begin
            state_n = IDLE;
            cnt_n   = '0;
            if (state == WAIT_B) valid_n = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_rise) begin
                        a_n     = uio_in;
                        op_n    = ui_in[2];
                        valid_n = 1'b0;
                        err_n   = 1'b0;
                        cnt_n   = CNT_W'(TIMEOUT_CYCLES - 1);
                        state_n = WAIT_B;
                    end
                end
                WAIT_B: begin
                    if (b_rise) begin
                        b_n     = uio_in;
                        state_n = COMPUTE;
                    end else if (cnt == '0) begin
                        err_n   = 1'b1;
                        state_n = IDLE;
                    end else begin
                        cnt_n = cnt - 1'b1;
                    end
                end
                COMPUTE: begin
                    if (op_q) begin
                        result_n = diff[7:0];
                        carry_n  = diff[8];
                    end else begin
                        result_n = sum[7:0];
                        carry_n  = sum[8];
                    end
                    valid_n = 1'b1;
                    cnt_n   = CNT_W'(HOLD_CYCLES - 1);
                    state_n = SHOW;
                end
                SHOW: begin
                    if (cnt == '0) state_n = IDLE;
                    else           cnt_n   = cnt - 1'b1;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    assign uo_out  = ui_in[3] ? {busy, carry_q, valid_q, err_q, 2'b00, state} : result_q;
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;
    assign unused  = &{1'b0, ena, ui_in[7:5]};
endmodule

// File: tb/tb_led_adder_sequencer.sv
// Scoreboard bench: stimulus queues expected results and status probes; a negedge
// monitor owns the view select and does every comparison against the DUT outputs.
module tb_led_adder_sequencer;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena = 1'b1;
    logic [7:0] ui_in, uio_in, uo_out, uio_out, uio_oe;
    logic       start_s, b_s, op_s, view, abort_s;

    typedef struct {
        string      name;
        logic [7:0] res;
        logic [7:0] stat;
    } exp_t;

    typedef struct {
        string      name;
        logic       v;
        logic [7:0] exp;
        int         kind;
    } probe_t;

    exp_t       sb_q[$];
    probe_t     pr_q[$];
    exp_t       e;
    probe_t     p;
    int         n_checks = 0;
    int         n_fail   = 0;
    logic       prev_valid = 1'b0;
    logic [7:0] st;

    assign ui_in = {3'b000, abort_s, view, op_s, b_s, start_s};

    led_adder_sequencer #(
        .HOLD_CYCLES(16),
        .TIMEOUT_CYCLES(4),
        .CNT_W(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .ena(ena),
        .ui_in(ui_in),
        .uio_in(uio_in),
        .uo_out(uo_out),
        .uio_out(uio_out),
        .uio_oe(uio_oe)
    );

    always #10 clk = ~clk;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h", nm, act, exp);
        end
    endtask

    // Valid rising in the status view marks a freshly computed result.
    always @(negedge clk) begin
        view = 1'b1;
        #1;
        st = uo_out;
        if (rst_n && st[5] && !prev_valid) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_result", 8'd1, 8'd0);
            end else begin
                e = sb_q.pop_front();
                chk({e.name, "_stat"}, st, e.stat);
                view = 1'b0;
                #1;
                chk({e.name, "_res"}, uo_out, e.res);
                view = 1'b1;
            end
        end
        prev_valid = st[5];
        while (pr_q.size() != 0) begin
            p = pr_q.pop_front();
            if (p.kind == 1) begin
                chk(p.name, 8'(sb_q.size()), 8'd0);
            end else begin
                view = p.v;
                #1;
                chk(p.name, uo_out, p.exp);
            end
        end
        view = 1'b1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic probe(input string nm, input logic v, input logic [7:0] exp, input int kind = 0);
        probe_t q;
        q.name = nm;
        q.v    = v;
        q.exp  = exp;
        q.kind = kind;
        pr_q.push_back(q);
    endtask

    task automatic expect_result(input string nm, input logic [7:0] res, input logic [7:0] stat);
        exp_t x;
        x.name = nm;
        x.res  = res;
        x.stat = stat;
        sb_q.push_back(x);
    endtask

    // Start, B strobe on the next edge, COMPUTE on the one after; returns just after that edge.
    task automatic do_op(input string nm, input logic [7:0] a, input logic [7:0] b, input logic sub,
                         input logic [7:0] res, input logic [7:0] stat, input logic [7:0] comp_stat);
        uio_in = a; op_s = sub; start_s = 1'b1;
        tick();
        start_s = 1'b0; b_s = 1'b1; uio_in = b;
        tick();
        b_s = 1'b0;
        probe({nm, "_compute"}, 1'b1, comp_stat);
        expect_result(nm, res, stat);
        tick();
    endtask

    initial begin
        rst_n = 1'b0; start_s = 1'b0; b_s = 1'b0; op_s = 1'b0; abort_s = 1'b0; uio_in = 8'h00;
        #1;
        probe("reset_res", 1'b0, 8'h00);
        probe("reset_stat", 1'b1, 8'h00);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        do_op("add_basic", 8'h2A, 8'h15, 1'b0, 8'h3F, 8'hA3, 8'h82);
        repeat (15) tick();
        probe("show_last_cycle", 1'b1, 8'hA3);
        tick();
        probe("idle_after_show", 1'b1, 8'h20);
        probe("result_persists", 1'b0, 8'h3F);

        do_op("add_ovf", 8'hF0, 8'h20, 1'b0, 8'h10, 8'hE3, 8'h82);
        repeat (16) tick();
        probe("idle_carry", 1'b1, 8'h60);
        do_op("sub_borrow", 8'h05, 8'h07, 1'b1, 8'hFE, 8'hE3, 8'hC2);
        repeat (16) tick();
        do_op("sub_plain", 8'h07, 8'h05, 1'b1, 8'h02, 8'hA3, 8'hC2);
        repeat (16) tick();
        probe("idle_sub", 1'b1, 8'h20);

        uio_in = 8'h55; op_s = 1'b0; start_s = 1'b1;
        tick();
        start_s = 1'b0;
        probe("tmo_wait_first", 1'b1, 8'h81);
        repeat (3) tick();
        probe("tmo_wait_last", 1'b1, 8'h81);
        tick();
        probe("tmo_err", 1'b1, 8'h10);
        probe("tmo_res_kept", 1'b0, 8'h02);
        b_s = 1'b1; uio_in = 8'h33;
        tick();
        b_s = 1'b0;
        tick();
        probe("tmo_late_b", 1'b1, 8'h10);

        uio_in = 8'h11; start_s = 1'b1;
        tick();
        start_s = 1'b0;
        probe("abort_wait_pre", 1'b1, 8'h81);
        abort_s = 1'b1;
        tick();
        probe("abort_wait_stat", 1'b1, 8'h00);
        probe("abort_wait_res", 1'b0, 8'h02);
        start_s = 1'b1;
        tick();
        probe("abort_blocks_start", 1'b1, 8'h00);
        abort_s = 1'b0;
        tick();
        probe("held_start_no_rise", 1'b1, 8'h00);
        start_s = 1'b0;
        tick();

        uio_in = 8'h40; start_s = 1'b1;
        tick();
        start_s = 1'b0; b_s = 1'b1; uio_in = 8'h01;
        tick();
        b_s = 1'b0; abort_s = 1'b1;
        probe("abort_comp_pre", 1'b1, 8'h82);
        tick();
        abort_s = 1'b0;
        probe("abort_comp_stat", 1'b1, 8'h00);
        probe("abort_comp_res", 1'b0, 8'h02);
        tick();

        do_op("add_wrap", 8'h80, 8'h81, 1'b0, 8'h01, 8'hE3, 8'h82);
        repeat (3) tick();
        rst_n = 1'b0; start_s = 1'b1; uio_in = 8'h9C; op_s = 1'b1;
        probe("async_rst_res", 1'b0, 8'h00);
        probe("async_rst_stat", 1'b1, 8'h00);
        tick();
        rst_n = 1'b1;
        tick();
        probe("start_through_reset", 1'b1, 8'h81);
        start_s = 1'b0; b_s = 1'b1; uio_in = 8'h1C;
        tick();
        b_s = 1'b0;
        expect_result("sub_after_reset", 8'h80, 8'hA3);
        tick();
        repeat (16) tick();
        probe("sb_drained", 1'b0, 8'h00, 1);
        tick();
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
